// File: rtl/prog_line_fetcher.sv
// Program-cache refill engine: fetches a 64-byte line as 16 in-order word reads and queues it.
// Optional duplicate-request suppression is enabled by defining PROG_FETCH_DEDUP_EN.
module prog_line_fetcher #(
    parameter int LINE_WIDTH      = 512,
    parameter int WORD_WIDTH      = 32,
    parameter int WORDS_PER_LINE  = 16,
    parameter int TAG_WIDTH       = 18,
    parameter int INDEX_WIDTH     = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    input  logic [INDEX_WIDTH-1:0] req_index,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [31:0]            mem_addr,
    input  logic                   mem_rsp_valid,
    input  logic [WORD_WIDTH-1:0]  mem_rsp_data,
    input  logic                   mem_rsp_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [LINE_WIDTH-1:0]  out_data,
    output logic                   fetch_err,
    output logic [1:0]             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends combinationally on the matching ready.

    localparam int CW = $clog2(WORDS_PER_LINE) + 1;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [CW-1:0]          issue_cnt;
    logic [CW-1:0]          rsp_cnt;
    logic [3:0]             outstanding;
    logic [LINE_WIDTH-1:0]  line_q;
    logic [LINE_WIDTH-1:0]  line_d;

    logic [TAG_WIDTH-1:0]   fifo_tag   [OUT_DEPTH];
    logic [INDEX_WIDTH-1:0] fifo_index [OUT_DEPTH];
    logic [LINE_WIDTH-1:0]  fifo_data  [OUT_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            fifo_count;

    logic room, dup_hit, accept, issue_fire, rsp_take, push, pop, err_hit;

    assign room       = fifo_count < (PW+1)'(OUT_DEPTH);
    assign out_valid  = fifo_count != '0;
    assign pop        = out_valid & out_ready;
    assign issue_fire = mem_req_valid & mem_req_ready;
    assign rsp_take   = (state_q != S_IDLE) & mem_rsp_valid;
    assign mem_addr   = {tag_q, index_q, issue_cnt[CW-2:0], 2'b00};
    assign dbg_state  = state_q;

    assign out_tag   = out_valid ? fifo_tag[rd_ptr]   : '0;
    assign out_index = out_valid ? fifo_index[rd_ptr] : '0;
    assign out_data  = out_valid ? fifo_data[rd_ptr]  : '0;

`ifdef PROG_FETCH_DEDUP_EN
    logic [PW-1:0] off;
    always_comb begin
        dup_hit = 1'b0;
        off     = '0;
        if (state_q == S_FETCH && req_tag == tag_q && req_index == index_q)
            dup_hit = 1'b1;
        // Only entries between the read pointer and read pointer + count are live.
        for (int i = 0; i < OUT_DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < fifo_count && fifo_tag[i] == req_tag && fifo_index[i] == req_index)
                dup_hit = 1'b1;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        line_d = line_q;
        line_d[int'(rsp_cnt[CW-2:0]) * WORD_WIDTH +: WORD_WIDTH] = mem_rsp_data;
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        push          = 1'b0;
        err_hit       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = reset & (room | dup_hit);
                accept    = req_valid & req_ready & ~dup_hit;
                if (accept)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                req_ready     = reset & dup_hit;
                mem_req_valid = reset & (issue_cnt < CW'(WORDS_PER_LINE))
                                      & (outstanding < 4'(MAX_OUTSTANDING));
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        err_hit = 1'b1;
                        state_d = S_DRAIN;
                    end else if (rsp_cnt == LAST_WORD) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (outstanding == 4'd0)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tag_q       <= '0;
            index_q     <= '0;
            issue_cnt   <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
            line_q      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            fetch_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fetch_err <= err_hit;
            if (accept) begin
                tag_q       <= req_tag;
                index_q     <= req_index;
                issue_cnt   <= '0;
                rsp_cnt     <= '0;
                outstanding <= '0;
            end else if (state_q != S_IDLE) begin
                if (issue_fire)
                    issue_cnt <= issue_cnt + CW'(1);
                if (rsp_take)
                    rsp_cnt <= rsp_cnt + CW'(1);
                if (state_q == S_FETCH && mem_rsp_valid)
                    line_q <= line_d;
                case ({issue_fire, rsp_take && outstanding != 4'd0})
                    2'b10:   outstanding <= outstanding + 4'd1;
                    2'b01:   outstanding <= outstanding - 4'd1;
                    default: outstanding <= outstanding;
                endcase
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The final word is merged via line_d so the line is pushed on the same edge it completes.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tag[wr_ptr]   <= tag_q;
            fifo_index[wr_ptr] <= index_q;
            fifo_data[wr_ptr]  <= line_d;
        end
    end

endmodule

// File: tb/tb_prog_line_fetcher.sv
// Bench for prog_line_fetcher: in-order memory model with latency/stall/error control and a line scoreboard.
module tb_prog_line_fetcher;

    localparam int EW = 18 + 8 + 512;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [17:0]  req_tag;
    logic [7:0]   req_index;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_addr;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         mem_rsp_err;
    logic         out_valid;
    logic         out_ready;
    logic [17:0]  out_tag;
    logic [7:0]   out_index;
    logic [511:0] out_data;
    logic         fetch_err;
    logic [1:0]   dbg_state;

    prog_line_fetcher dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_index(req_index),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_index(out_index),
        .out_data(out_data), .fetch_err(fetch_err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];

    // memory model and monitor state
    int cyc = 0, lat = 1, stall_cnt = 0;
    int n_issued, n_rsp, n_issue_after_err, n_rsp_after_err, n_err_pulse, n_outv, n_pops, max_out;
    bit err_en = 0, err_seen = 0, inject = 0, flush = 0;
    logic [31:0] err_addr = '0;
    int due_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] addr_log[$];

    function automatic logic [31:0] addr_of(input logic [17:0] t, input logic [7:0] ix, input int w);
        logic [3:0] w4;
        w4 = w[3:0];
        return {t, ix, w4, 2'b00};
    endfunction

    function automatic logic [EW-1:0] exp_entry(input logic [17:0] t, input logic [7:0] ix);
        logic [511:0] line;
        for (int i = 0; i < 16; i++) line[32*i +: 32] = addr_of(t, ix, i);
        return {t, ix, line};
    endfunction

    // Memory drives at the falling edge and observes handshakes just before the rising edge.
    initial begin
        logic [31:0]   d;
        logic [EW-1:0] e;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0;
            if (inject) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF; inject = 0;
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                d = dat_q.pop_front();
                void'(due_q.pop_front());
                mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = err_en && (d == err_addr);
            end
            mem_req_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            #4;
            if (flush) begin due_q.delete(); dat_q.delete(); flush = 0; end
            if (reset && mem_req_valid && mem_req_ready) begin
                due_q.push_back(cyc + lat); dat_q.push_back(mem_addr); addr_log.push_back(mem_addr);
                n_issued++;
                if (err_seen) n_issue_after_err++;
            end
            if (reset && mem_rsp_valid) begin
                n_rsp++;
                if (err_seen) n_rsp_after_err++;
            end
            if (mem_rsp_valid && mem_rsp_err) err_seen = 1;
            if (n_issued - n_rsp > max_out) max_out = n_issued - n_rsp;
            if (fetch_err) n_err_pulse++;
            if (out_valid) n_outv++;
            if (reset && out_valid && out_ready) begin
                tests++; n_pops++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_unexpected: got tag=%h index=%h, expected no entry", out_tag, out_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_tag, out_index, out_data} !== e) begin
                        fails++;
                        $display("FAIL scoreboard_line: got %h expected %h", {out_tag, out_index, out_data}, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        @(negedge clk);
        n_issued = 0; n_rsp = 0; n_issue_after_err = 0; n_rsp_after_err = 0;
        n_err_pulse = 0; n_outv = 0; n_pops = 0; max_out = 0; err_seen = 0;
        addr_log.delete();
    endtask

    task automatic do_req(input logic [17:0] t, input logic [7:0] ix, output int waited, output bit ok);
        ok = 0; waited = 0;
        @(negedge clk);
        req_valid = 1'b1; req_tag = t; req_index = ix;
        for (int i = 0; i < 300; i++) begin
            #4;
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        #4;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #4;
            if (dbg_state == 2'd0 && !out_valid && due_q.size() == 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        int w; bit ok;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL rst_fetch_err: got %b want 0", fetch_err); end
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        @(negedge clk); reset = 1'b1;
        do_req(18'h00155, 8'h11, w, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rst_first_accept: timed out"); end
        repeat (4) @(negedge clk);
        #4;
        tests++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL rst_mid_fetch_state: got %0d want 1", dbg_state); end
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; flush = 1; inject = 1;
        @(negedge clk); #4;
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rel_state: got %0d want 0", dbg_state); end
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL rel_mem_req_valid: got %b want 0", mem_req_valid); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rel_mem_addr: got %h want 0", mem_addr); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
        tests++; if ({out_tag, out_index, out_data} !== '0) begin fails++; $display("FAIL rel_out_fields: got tag=%h index=%h want 0", out_tag, out_index); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL rel_fetch_err: got %b want 0", fetch_err); end
        @(negedge clk); #4;
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rel_ignore_rsp_state: got %0d want 0", dbg_state); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rel_req_ready: got %b want 1", req_ready); end
        exp_q.push_back(exp_entry(18'h0ABCD, 8'h22));
        do_req(18'h0ABCD, 8'h22, w, ok);
        tests++; if (!ok || w != 0) begin fails++; $display("FAIL rel_accept_next: ok=%0d waited=%0d want ok=1 waited=0", ok, w); end
        wait_done(ok);
        tests++; if (!ok || exp_q.size() != 0) begin fails++; $display("FAIL rel_fetch_done: ok=%0d left=%0d want 1/0", ok, exp_q.size()); end
    endtask

    task automatic test_basic();
        int w, k; bit ok;
        lat = 1; out_ready = 1'b1;
        clear_stats();
        exp_q.push_back(exp_entry(18'h2A5C5, 8'h3F));
        do_req(18'h2A5C5, 8'h3F, w, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_accept: timed out"); end
        k = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #4; k++;
            if (out_valid) break;
        end
        tests++; if (k - 1 != 17) begin fails++; $display("FAIL basic_latency: got %0d cycles want 17", k - 1); end
        tests++; if (out_data[31:0] !== addr_of(18'h2A5C5, 8'h3F, 0)) begin fails++; $display("FAIL basic_word0: got %h want %h", out_data[31:0], addr_of(18'h2A5C5, 8'h3F, 0)); end
        tests++; if (out_index !== 8'h3F) begin fails++; $display("FAIL basic_index: got %h want 3f", out_index); end
        tests++; if (out_tag !== 18'h2A5C5) begin fails++; $display("FAIL basic_tag: got %h want 2a5c5", out_tag); end
        wait_done(ok);
        tests++; if (addr_log.size() != 16) begin fails++; $display("FAIL basic_num_reads: got %0d want 16", addr_log.size()); end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (addr_log[i] !== addr_of(18'h2A5C5, 8'h3F, i)) begin
                fails++; $display("FAIL basic_addr%0d: got %h want %h", i, addr_log[i], addr_of(18'h2A5C5, 8'h3F, i));
            end
        end
        tests++; if (!ok || exp_q.size() != 0) begin fails++; $display("FAIL basic_done: ok=%0d left=%0d want 1/0", ok, exp_q.size()); end
    endtask

    task automatic test_stall();
        int w; bit ok;
        lat = 8; out_ready = 1'b1;
        clear_stats();
        exp_q.push_back(exp_entry(18'h2A5C5, 8'h3F));
        stall_cnt = 11;
        do_req(18'h2A5C5, 8'h3F, w, ok);
        tests++; if (!ok) begin fails++; $display("FAIL stall_accept: timed out"); end
        wait_done(ok);
        tests++; if (max_out > 4 || max_out < 1) begin fails++; $display("FAIL stall_outstanding: max %0d want 1..4", max_out); end
        tests++; if (n_issued != 16) begin fails++; $display("FAIL stall_num_reads: got %0d want 16", n_issued); end
        tests++; if (addr_log[15] !== addr_of(18'h2A5C5, 8'h3F, 15)) begin fails++; $display("FAIL stall_last_addr: got %h want %h", addr_log[15], addr_of(18'h2A5C5, 8'h3F, 15)); end
        tests++; if (!ok || exp_q.size() != 0) begin fails++; $display("FAIL stall_done: ok=%0d left=%0d want 1/0", ok, exp_q.size()); end
    endtask

    task automatic test_error();
        int w; bit ok;
        lat = 8; out_ready = 1'b1;
        clear_stats();
        err_addr = addr_of(18'h01234, 8'h56, 5); err_en = 1;
        do_req(18'h01234, 8'h56, w, ok);
        tests++; if (!ok) begin fails++; $display("FAIL err_accept: timed out"); end
        wait_done(ok);
        err_en = 0;
        tests++; if (!ok) begin fails++; $display("FAIL err_return_idle: timed out, state %0d", dbg_state); end
        tests++; if (n_err_pulse != 1) begin fails++; $display("FAIL err_pulse: got %0d cycles want 1", n_err_pulse); end
        tests++; if (n_issue_after_err != 0) begin fails++; $display("FAIL err_no_more_reads: got %0d want 0", n_issue_after_err); end
        tests++; if (n_issued != 9) begin fails++; $display("FAIL err_total_reads: got %0d want 9", n_issued); end
        tests++; if (n_rsp_after_err != 3) begin fails++; $display("FAIL err_drained: got %0d want 3", n_rsp_after_err); end
        tests++; if (n_outv != 0) begin fails++; $display("FAIL err_no_push: out_valid seen %0d cycles want 0", n_outv); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL err_slot_released: req_ready %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        int w; bit ok1, ok2, ok;
        lat = 1;
        clear_stats();
        out_ready = 1'b0;
        exp_q.push_back(exp_entry(18'h3FFFF, 8'h01));
        do_req(18'h3FFFF, 8'h01, w, ok1);
        exp_q.push_back(exp_entry(18'h00001, 8'hFE));
        do_req(18'h00001, 8'hFE, w, ok2);
        tests++; if (!ok1 || !ok2) begin fails++; $display("FAIL b2b_accepts: ok=%0d/%0d want 1/1", ok1, ok2); end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #4;
            if (dbg_state == 2'd0) begin ok = 1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL b2b_complete: timed out"); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready: got %b want 0", req_ready); end
        tests++; if (out_tag !== 18'h3FFFF) begin fails++; $display("FAIL b2b_head: got %h want 3ffff", out_tag); end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0; #4;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_reopen: got %b want 1", req_ready); end
        tests++; if (out_tag !== 18'h00001) begin fails++; $display("FAIL b2b_second_head: got %h want 00001", out_tag); end
        @(negedge clk); out_ready = 1'b1;
        wait_done(ok);
        tests++; if (!ok || exp_q.size() != 0 || n_pops != 2) begin fails++; $display("FAIL b2b_drain: ok=%0d left=%0d pops=%0d want 1/0/2", ok, exp_q.size(), n_pops); end
    endtask

    task automatic test_dedup();
        int w; bit ok;
        lat = 1; out_ready = 1'b1;
        clear_stats();
        exp_q.push_back(exp_entry(18'h15A5A, 8'h77));
        do_req(18'h15A5A, 8'h77, w, ok);
        repeat (3) @(negedge clk);
`ifndef PROG_FETCH_DEDUP_EN
        exp_q.push_back(exp_entry(18'h15A5A, 8'h77));
`endif
        do_req(18'h15A5A, 8'h77, w, ok);
        tests++; if (!ok) begin fails++; $display("FAIL dup_accept: timed out"); end
`ifdef PROG_FETCH_DEDUP_EN
        tests++; if (w != 0) begin fails++; $display("FAIL dup_immediate: waited %0d want 0", w); end
`else
        tests++; if (w == 0) begin fails++; $display("FAIL dup_wait: waited %0d want >0", w); end
`endif
        wait_done(ok);
`ifdef PROG_FETCH_DEDUP_EN
        tests++; if (n_issued != 16 || n_pops != 1) begin fails++; $display("FAIL dup_counts: reads=%0d entries=%0d want 16/1", n_issued, n_pops); end
`else
        tests++; if (n_issued != 32 || n_pops != 2) begin fails++; $display("FAIL dup_counts: reads=%0d entries=%0d want 32/2", n_issued, n_pops); end
`endif
        tests++; if (!ok || exp_q.size() != 0) begin fails++; $display("FAIL dup_done: ok=%0d left=%0d want 1/0", ok, exp_q.size()); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_tag = '0; req_index = '0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_error();
        test_back_to_back();
        test_dedup();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
